// File: rtl/i3c_reset_pattern_gen_pkg.sv
// I3C target reset pattern generator: shared types.
// State encoding, toggle terminal count and line-drive decode.
package i3c_reset_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP   = 3'd1,
    ST_TOGGLE = 3'd2,
    ST_SCL_HI = 3'd3,
    ST_SR     = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  localparam logic [3:0] K_LAST = 4'd13;

  function automatic logic scl_pull(
    input state_e s
  );
    return (s == ST_PREP) || (s == ST_TOGGLE);
  endfunction

  // Even k pulls SDA low; Sr is the only fall with SCL released.
  function automatic logic sda_pull(
    input state_e     s,
    input logic [3:0] k
  );
    return ((s == ST_TOGGLE) && !k[0]) ||
           (s == ST_SR);
  endfunction

endpackage

// File: rtl/i3c_rpg_phase_timer.sv
// Phase timer for the reset pattern generator.
// Counts 0..PHASE_CYC-1, holds on request, flags terminal count.
module i3c_rpg_phase_timer #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       en_i,
  input  logic       hold_i,
  output logic [7:0] cnt_nxt_o,
  output logic       tc_o
);

  localparam logic [7:0] LAST = 8'(PHASE_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: cleared while disabled, wraps on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tc_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign cnt_nxt_o = cnt_d;

  // Count register.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i3c_reset_pattern_gen.sv
// I3C controller-side target reset pattern (SRST) generator.
// 14 SDA toggles under SCL low, then Sr and P.
module i3c_reset_pattern_gen
  import i3c_reset_pattern_gen_pkg::*;
#(
  parameter int unsigned PHASE_CYC    = 4,
  parameter int unsigned SCL_WAIT_MAX = 255
) (
  input  logic clk,
  input  logic RST,
  input  logic iStart,
  input  logic iAbort,
  input  logic pin_SCL_in,
  output logic oSCL_od,
  output logic oSDA_od,
  output logic oBusy,
  output logic oDone,
  output logic oErr
);

  localparam logic [7:0] PC_LAST   = 8'(PHASE_CYC - 1);
  localparam logic [7:0] WAIT_LAST = 8'(SCL_WAIT_MAX - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] k_q;
  logic [3:0] k_d;
  logic [7:0] wait_q;
  logic [7:0] wait_d;

  logic scl_q;
  logic sda_q;
  logic busy_q;
  logic done_q;
  logic err_q;
  logic err_d;
  logic done_d;

  logic       tmr_en;
  logic       hold;
  logic       tc;
  logic [7:0] cnt_nxt;
  logic       timeout;

  assign tmr_en = (state_q != ST_IDLE);
  assign hold   = (state_q == ST_SCL_HI) && !pin_SCL_in;

  assign timeout = (state_q == ST_SCL_HI) &&
                   !pin_SCL_in &&
                   (wait_q >= WAIT_LAST);

  i3c_rpg_phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_timer (
    .clk       (clk),
    .RST       (RST),
    .en_i      (tmr_en),
    .hold_i    (hold),
    .cnt_nxt_o (cnt_nxt),
    .tc_o      (tc)
  );

  // Next state, toggle index and error pulse.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (iStart) state_d = ST_PREP;
      end
      ST_PREP: begin
        if (tc) begin
          state_d = ST_TOGGLE;
          k_d     = '0;
        end
      end
      ST_TOGGLE: begin
        if (tc) begin
          if (k_q == K_LAST) begin
            state_d = ST_SCL_HI;
            k_d     = '0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      ST_SCL_HI: begin
        if (tc) state_d = ST_SR;
      end
      ST_SR: begin
        if (tc) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tc) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
    if ((state_q != ST_IDLE) && (iAbort || timeout)) begin
      state_d = ST_IDLE;
      k_d     = '0;
      err_d   = 1'b1;
    end
  end

  // Saturating count of low SCL readbacks while SCL is released.
  always_comb begin
    wait_d = '0;
    if (state_q == ST_SCL_HI) begin
      wait_d = wait_q;
      if (!pin_SCL_in && (wait_q != 8'hFF)) begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  // Done lands in the final STOP cycle, so it looks one count ahead.
  assign done_d = (state_d == ST_STOP) && (cnt_nxt == PC_LAST);

  // State, counters and registered line drives.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      scl_q   <= scl_pull(state_d);
      sda_q   <= sda_pull(state_d, k_d);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oSCL_od = scl_q;
  assign oSDA_od = sda_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oErr    = err_q;

endmodule

// File: tb/tb_i3c_reset_pattern_gen.sv
// Bench for the I3C target reset pattern generator.
// Cycle-level expected waveform plus a line-level SRST detector.
module tb_i3c_reset_pattern_gen;

  localparam int P = 4;

  typedef struct packed {
    logic scl;
    logic sda;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  logic clk;
  logic RST;
  logic iStart;
  logic iAbort;
  logic pin1;
  logic pin2;
  logic scl1, sda1, busy1, done1, err1;
  logic scl2, sda2, busy2, done2, err2;

  int   stretch = 0;
  logic stuck2  = 1'b0;
  int   rel     = 0;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q[$];
  exp_t obs;

  int   det_cnt   = 0;
  int   det_fires = 0;
  logic det_sr    = 1'b0;
  logic det_pscl  = 1'b1;
  logic det_psda  = 1'b1;

  i3c_reset_pattern_gen #(
    .PHASE_CYC    (P),
    .SCL_WAIT_MAX (255)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .iStart     (iStart),
    .iAbort     (iAbort),
    .pin_SCL_in (pin1),
    .oSCL_od    (scl1),
    .oSDA_od    (sda1),
    .oBusy      (busy1),
    .oDone      (done1),
    .oErr       (err1)
  );

  i3c_reset_pattern_gen #(
    .PHASE_CYC    (P),
    .SCL_WAIT_MAX (16)
  ) dut16 (
    .clk        (clk),
    .RST        (RST),
    .iStart     (iStart),
    .iAbort     (iAbort),
    .pin_SCL_in (pin2),
    .oSCL_od    (scl2),
    .oSDA_od    (sda2),
    .oBusy      (busy2),
    .oDone      (done2),
    .oErr       (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target clock stretch: SCL reads low for `stretch` cycles after release.
  always @(negedge clk) begin
    if (scl1 !== 1'b0) rel <= 0;
    else if (rel < 1000) rel <= rel + 1;
  end

  assign pin1 = (scl1 === 1'b0) && (rel > stretch);
  assign pin2 = !stuck2 && (scl2 === 1'b0);

  // Line-level SRST detector on dut: 14 SDA edges under SCL low, Sr, P.
  always @(negedge clk) begin
    det_pscl <= ~scl1;
    det_psda <= ~sda1;
    if (scl1 === 1'b1) begin
      if (det_pscl) det_cnt <= ((~sda1) != det_psda) ? 1 : 0;
      else if ((~sda1) != det_psda) det_cnt <= det_cnt + 1;
      det_sr <= 1'b0;
    end else if (det_psda && (sda1 === 1'b1)) begin
      det_sr <= det_pscl && (det_cnt >= 14);
    end else if (!det_psda && (sda1 === 1'b0) && det_sr) begin
      det_fires <= det_fires + 1;
      det_sr    <= 1'b0;
      det_cnt   <= 0;
    end
  end

  function automatic exp_t mk(bit c, bit d, bit b, bit dn, bit e);
    return {c, d, b, dn, e};
  endfunction

  function automatic void push_n(int n, exp_t e);
    for (int i = 0; i < n; i++) q.push_back(e);
  endfunction

  // Spec waveform from the first busy cycle onward, ending in IDLE.
  function automatic void build_nominal(int s);
    q.delete();
    push_n(P, mk(1, 0, 1, 0, 0));
    for (int k = 0; k < 14; k++) push_n(P, mk(1, (k % 2) == 0, 1, 0, 0));
    push_n(P + s, mk(0, 0, 1, 0, 0));
    push_n(P, mk(0, 1, 1, 0, 0));
    push_n(P - 1, mk(0, 0, 1, 0, 0));
    push_n(1, mk(0, 0, 1, 1, 0));
    push_n(1, mk(0, 0, 0, 0, 0));
  endfunction

  function automatic void cut(int a);
    while (q.size() > a) void'(q.pop_back());
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    iStart = 1'b1;
    @(posedge clk); #1;
    obs = {scl1, sda1, busy1, done1, err1};
    n_total++;
    if (obs !== 5'b0) $display("FAIL reset_dut got=%b want=00000", obs);
    else n_pass++;
    obs = {scl2, sda2, busy2, done2, err2};
    n_total++;
    if (obs !== 5'b0) $display("FAIL reset_dut16 got=%b want=00000", obs);
    else n_pass++;
    iStart = 1'b0;
    RST = 1'b0;
    iAbort = 1'b1;
    @(posedge clk); #1;
    iAbort = 1'b0;
    obs = {scl1, sda1, busy1, done1, err1};
    n_total++;
    if (obs !== 5'b0) $display("FAIL idle_abort got=%b want=00000", obs);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int busy_n;
    int falls;
    int f0;
    logic psda;
    stretch = 0;
    build_nominal(0);
    f0 = det_fires;
    busy_n = 0;
    falls = 0;
    psda = 1'b0;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL nominal cyc=%0d got=%b want=%b", i, obs, q[i]);
      else n_pass++;
      if (busy1 === 1'b1) busy_n++;
      if ((scl1 === 1'b1) && (sda1 === 1'b1) && !psda) falls++;
      psda = sda1;
      @(posedge clk); #1;
    end
    n_total++;
    if (busy_n !== 18 * P) $display("FAIL busy_len got=%0d want=%0d", busy_n, 18 * P);
    else n_pass++;
    n_total++;
    if (falls !== 7) $display("FAIL sda_falls got=%0d want=7", falls);
    else n_pass++;
    n_total++;
    if (det_fires !== f0 + 1) $display("FAIL detector got=%0d want=%0d", det_fires - f0, 1);
    else n_pass++;
  endtask

  task automatic test_stretch(input int s);
    int busy_n;
    int f0;
    stretch = s;
    build_nominal(s);
    f0 = det_fires;
    busy_n = 0;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL stretch%0d cyc=%0d got=%b want=%b", s, i, obs, q[i]);
      else n_pass++;
      if (busy1 === 1'b1) busy_n++;
      @(posedge clk); #1;
    end
    n_total++;
    if (busy_n !== 18 * P + s) $display("FAIL stretch_len got=%0d want=%0d", busy_n, 18 * P + s);
    else n_pass++;
    n_total++;
    if (det_fires !== f0 + 1) $display("FAIL stretch_det got=%0d want=1", det_fires - f0);
    else n_pass++;
    stretch = 0;
  endtask

  task automatic test_timeout();
    build_nominal(0);
    cut(16 * P - 4);
    push_n(16, mk(0, 0, 1, 0, 0));
    push_n(1, mk(0, 0, 0, 0, 1));
    push_n(2, mk(0, 0, 0, 0, 0));
    stuck2 = 1'b1;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl2, sda2, busy2, done2, err2};
      n_total++;
      if (obs !== q[i])
        $display("FAIL timeout cyc=%0d got=%b want=%b", i, obs, q[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    stuck2 = 1'b0;
  endtask

  task automatic test_abort(input int a, input bit chk_det);
    int f0;
    build_nominal(0);
    cut(a);
    push_n(1, mk(0, 0, 0, 0, 1));
    push_n(2, mk(0, 0, 0, 0, 0));
    f0 = det_fires;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL abort@%0d cyc=%0d got=%b want=%b", a, i, obs, q[i]);
      else n_pass++;
      iAbort = (i == a - 1);
      @(posedge clk); #1;
    end
    iAbort = 1'b0;
    if (chk_det) begin
      n_total++;
      if (det_fires !== f0) $display("FAIL abort_det got=%0d want=0", det_fires - f0);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    int a;
    a = P + 9 * P + int'($urandom_range(0, P - 1));
    build_nominal(0);
    cut(a);
    push_n(3, mk(0, 0, 0, 0, 0));
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL rst_mid cyc=%0d got=%b want=%b", i, obs, q[i]);
      else n_pass++;
      RST = (i == a - 1);
      @(posedge clk); #1;
    end
    build_nominal(0);
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL rst_fresh cyc=%0d got=%b want=%b", i, obs, q[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_filter();
    int f0;
    build_nominal(0);
    push_n(4, mk(0, 0, 0, 0, 0));
    f0 = det_fires;
    iStart = 1'b1;
    iAbort = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    iAbort = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      obs = {scl1, sda1, busy1, done1, err1};
      n_total++;
      if (obs !== q[i])
        $display("FAIL start_filter cyc=%0d got=%b want=%b", i, obs, q[i]);
      else n_pass++;
      iStart = (i < 18 * P - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (det_fires !== f0 + 1) $display("FAIL filter_det got=%0d want=1", det_fires - f0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = det_fires;
    build_nominal(0);
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < q.size(); i++) begin
        obs = {scl1, sda1, busy1, done1, err1};
        n_total++;
        if (obs !== q[i])
          $display("FAIL b2b%0d cyc=%0d got=%b want=%b", rep, i, obs, q[i]);
        else n_pass++;
        iStart = (rep == 0) && (i == q.size() - 1);
        @(posedge clk); #1;
      end
    end
    n_total++;
    if (det_fires !== f0 + 2) $display("FAIL b2b_det got=%0d want=2", det_fires - f0);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    iStart = 1'b0;
    iAbort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_stretch(10);
    test_stretch(int'($urandom_range(1, 40)));
    test_timeout();
    test_abort(P + 5 * P + int'($urandom_range(0, P - 1)), 1'b1);
    for (int n = 0; n < 4; n++) test_abort(int'($urandom_range(1, 18 * P - 1)), 1'b0);
    test_rst_mid();
    test_start_filter();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
